// File: rtl/id_operand_stage.sv
`default_nettype none
// ---------------------------------------------------------------------
// id_operand_stage - decode operand read, MEM/WB bypass, load-use bubbles
// Revision: 1.0
// ---------------------------------------------------------------------
module id_operand_stage #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [31:0]     id_pc,
  output logic [AW-1:0]   rAddr,
  output logic [AW-1:0]   rAddr2,
  input  logic [DW-1:0]   rDout,
  input  logic [DW-1:0]   rDout2,
  input  logic            ex_load,
  input  logic [AW-1:0]   ex_dst,
  input  logic            mem_wEna,
  input  logic [AW-1:0]   mem_wAddr,
  input  logic [DW-1:0]   mem_res,
  input  logic            wb_wEna,
  input  logic [AW-1:0]   wb_wAddr,
  input  logic [DW-1:0]   wb_wIn,
  input  logic            hold,
  input  logic            flush,
  output logic            stall_if,
  output logic            ex_valid,
  output logic [31:0]     ex_pc,
  output logic [DW-1:0]   ex_opA,
  output logic [DW-1:0]   ex_opB,
  output logic [31:0]     ex_imm,
  output logic [AW-1:0]   ex_rs,
  output logic [AW-1:0]   ex_rt,
  output logic [AW-1:0]   ex_wAddr,
  output logic [5:0]      ex_opcode,
  output logic [5:0]      ex_funct,
  output logic [CNTW-1:0] bubble_cnt
);

  logic [5:0]      opcode_w;
  logic [5:0]      funct_w;
  logic [AW-1:0]   rs_w;
  logic [AW-1:0]   rt_w;
  logic [AW-1:0]   rd_w;
  logic [15:0]     imm16_w;
  logic [31:0]     imm_w;
  logic [AW-1:0]   wdst_w;
  logic [DW-1:0]   opA_w;
  logic [DW-1:0]   opB_w;
  logic            luh_w;

  logic            valid_q,  valid_d;
  logic [31:0]     pc_q,     pc_d;
  logic [DW-1:0]   opA_q,    opA_d;
  logic [DW-1:0]   opB_q,    opB_d;
  logic [31:0]     imm_q,    imm_d;
  logic [AW-1:0]   rs_q,     rs_d;
  logic [AW-1:0]   rt_q,     rt_d;
  logic [AW-1:0]   wAddr_q,  wAddr_d;
  logic [5:0]      opcode_q, opcode_d;
  logic [5:0]      funct_q,  funct_d;
  logic [CNTW-1:0] bcnt_q,   bcnt_d;

  assign opcode_w = id_instr[31:26];
  assign funct_w  = id_instr[5:0];
  assign rs_w     = id_instr[25:21];
  assign rt_w     = id_instr[20:16];
  assign rd_w     = id_instr[15:11];
  assign imm16_w  = id_instr[15:0];

  assign rAddr    = rs_w;
  assign rAddr2   = rt_w;

  // The regfile writes on the clock edge, so WB data must be forwarded here.
  always_comb begin
    opA_w = rDout;
    if (rs_w == '0)                          opA_w = '0;
    else if (mem_wEna && mem_wAddr == rs_w)  opA_w = mem_res;
    else if (wb_wEna && wb_wAddr == rs_w)    opA_w = wb_wIn;
  end

  always_comb begin
    opB_w = rDout2;
    if (rt_w == '0)                          opB_w = '0;
    else if (mem_wEna && mem_wAddr == rt_w)  opB_w = mem_res;
    else if (wb_wEna && wb_wAddr == rt_w)    opB_w = wb_wIn;
  end

  always_comb begin
    case (opcode_w)
      6'h0C, 6'h0D, 6'h0E: imm_w = {16'h0000, imm16_w};
      6'h0F:               imm_w = {imm16_w, 16'h0000};
      default:             imm_w = {{16{imm16_w[15]}}, imm16_w};
    endcase
  end

  always_comb begin
    case (opcode_w)
      6'h00:                      wdst_w = rd_w;
      6'h03:                      wdst_w = '1;
      6'h02, 6'h04, 6'h05, 6'h06,
      6'h07, 6'h28, 6'h29, 6'h2A,
      6'h2B:                      wdst_w = '0;
      default:                    wdst_w = rt_w;
    endcase
  end

  assign luh_w    = id_valid & ex_load & (ex_dst != '0) &
                    ((ex_dst == rs_w) | (ex_dst == rt_w));
  assign stall_if = luh_w & ~flush & ~hold & ~rst;

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    imm_d    = imm_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    wAddr_d  = wAddr_q;
    opcode_d = opcode_q;
    funct_d  = funct_q;
    bcnt_d   = bcnt_q;
    if (!hold) begin
      if (flush || luh_w) begin
        valid_d  = 1'b0;
        pc_d     = '0;
        opA_d    = '0;
        opB_d    = '0;
        imm_d    = '0;
        rs_d     = '0;
        rt_d     = '0;
        wAddr_d  = '0;
        opcode_d = '0;
        funct_d  = '0;
        // Flush takes priority: a squashed hazard is not counted.
        if (!flush && bcnt_q != '1) bcnt_d = bcnt_q + CNTW'(1);
      end else begin
        valid_d  = id_valid;
        pc_d     = id_pc;
        opA_d    = opA_w;
        opB_d    = opB_w;
        imm_d    = imm_w;
        rs_d     = rs_w;
        rt_d     = rt_w;
        wAddr_d  = id_valid ? wdst_w : '0;
        opcode_d = opcode_w;
        funct_d  = funct_w;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      imm_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      wAddr_q  <= '0;
      opcode_q <= '0;
      funct_q  <= '0;
      bcnt_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      imm_q    <= imm_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      wAddr_q  <= wAddr_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_pc      = pc_q;
  assign ex_opA     = opA_q;
  assign ex_opB     = opB_q;
  assign ex_imm     = imm_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_wAddr   = wAddr_q;
  assign ex_opcode  = opcode_q;
  assign ex_funct   = funct_q;
  assign bubble_cnt = bcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_operand_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------
// tb_id_operand_stage - scoreboard bench for the ID operand stage
// Revision: 1.0
// ---------------------------------------------------------------------
module tb_id_operand_stage;

  typedef logic [171:0] exp_t;
  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    exp_t        e;
  } row_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid;
  logic [31:0] id_instr, id_pc;
  logic [4:0]  rAddr, rAddr2;
  logic [31:0] rDout, rDout2;
  logic        ex_load;
  logic [4:0]  ex_dst;
  logic        mem_wEna;
  logic [4:0]  mem_wAddr;
  logic [31:0] mem_res;
  logic        wb_wEna;
  logic [4:0]  wb_wAddr;
  logic [31:0] wb_wIn;
  logic        hold, flush;
  logic        stall_if, ex_valid;
  logic [31:0] ex_pc, ex_opA, ex_opB, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_wAddr;
  logic [5:0]  ex_opcode, ex_funct;
  logic [15:0] bubble_cnt;

  logic [31:0] rf [32];
  exp_t        obs;
  exp_t        sb [$];
  exp_t        e;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  assign rDout  = (rAddr  == 5'd0) ? 32'd0 : rf[rAddr];
  assign rDout2 = (rAddr2 == 5'd0) ? 32'd0 : rf[rAddr2];
  assign obs = {ex_valid, ex_pc, ex_opA, ex_opB, ex_imm, ex_rs, ex_rt,
                ex_wAddr, ex_opcode, ex_funct, bubble_cnt};

  id_operand_stage #(.DW(32), .AW(5), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .rAddr(rAddr), .rAddr2(rAddr2), .rDout(rDout), .rDout2(rDout2),
    .ex_load(ex_load), .ex_dst(ex_dst), .mem_wEna(mem_wEna), .mem_wAddr(mem_wAddr),
    .mem_res(mem_res), .wb_wEna(wb_wEna), .wb_wAddr(wb_wAddr), .wb_wIn(wb_wIn),
    .hold(hold), .flush(flush), .stall_if(stall_if), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wAddr(ex_wAddr), .ex_opcode(ex_opcode),
    .ex_funct(ex_funct), .bubble_cnt(bubble_cnt)
  );

  function automatic exp_t mk(input logic v, input logic [31:0] pc, a, b, imm,
                              input logic [4:0] rs, rt, wa,
                              input logic [5:0] op, fn, input logic [15:0] bc);
    return {v, pc, a, b, imm, rs, rt, wa, op, fn, bc};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic quiet();
    ex_load = 1'b0; ex_dst = 5'd0;
    mem_wEna = 1'b0; mem_wAddr = 5'd0; mem_res = 32'd0;
    wb_wEna = 1'b0; wb_wAddr = 5'd0; wb_wIn = 32'd0;
    hold = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    id_valid = 1'b1; id_instr = itype(6'h08, 5'd5, 5'd6, 16'h0001); id_pc = 32'h100;
    ex_load = 1'b1; ex_dst = 5'd5;
    @(posedge clk); #1;
    total++;
    if (obs !== '0 || stall_if !== 1'b0) begin
      bad++; $display("FAIL reset_hold got=%h stall=%b exp=0 stall=0", obs, stall_if);
    end
    rst = 1'b0; ex_load = 1'b0;
    sb.push_back(mk(1, 32'h100, 32'h1005, 32'h1006, 32'h1, 5, 6, 6, 6'h08, 6'h01, 0));
    @(posedge clk); #1;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL reset_release got=%h exp=%h", obs, e); end
    ex_load = 1'b1;
    #3 rst = 1'b1;
    #1 total++;
    if (obs !== '0 || stall_if !== 1'b0) begin
      bad++; $display("FAIL reset_async got=%h stall=%b exp=0 stall=0", obs, stall_if);
    end
    #1 rst = 1'b0;
    quiet();
  endtask

  task automatic test_wb_bypass();
    wb_wEna = 1'b1; wb_wAddr = 5'd8; wb_wIn = 32'h22;
    id_valid = 1'b1; id_instr = rtype(5'd8, 5'd0, 5'd3, 6'h20); id_pc = 32'h104;
    @(posedge clk); #1;
    total++;
    if (rAddr !== 5'd8 || rAddr2 !== 5'd0) begin
      bad++; $display("FAIL raddr got=%0d/%0d exp=8/0", rAddr, rAddr2);
    end
    sb.push_back(mk(1, 32'h104, 32'h22, 32'h0, 32'h1820, 8, 0, 3, 6'h00, 6'h20, 0));
    @(posedge clk); #1;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL wb_bypass got=%h exp=%h", obs, e); end
  endtask

  task automatic test_mem_priority();
    mem_wEna = 1'b1; mem_wAddr = 5'd9; mem_res = 32'hAAAA;
    wb_wEna = 1'b1; wb_wAddr = 5'd9; wb_wIn = 32'hBBBB;
    id_instr = rtype(5'd1, 5'd9, 5'd4, 6'h20); id_pc = 32'h108;
    sb.push_back(mk(1, 32'h108, 32'h1001, 32'hAAAA, 32'h2020, 1, 9, 4, 6'h00, 6'h20, 0));
    @(posedge clk); #1;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL mem_priority got=%h exp=%h", obs, e); end
    mem_wAddr = 5'd0; wb_wAddr = 5'd0;
    id_instr = rtype(5'd0, 5'd0, 5'd4, 6'h20); id_pc = 32'h10C;
    sb.push_back(mk(1, 32'h10C, 32'h0, 32'h0, 32'h2020, 0, 0, 4, 6'h00, 6'h20, 0));
    @(posedge clk); #1;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL zero_reg got=%h exp=%h", obs, e); end
    quiet();
  endtask

  task automatic test_load_use();
    id_instr = itype(6'h08, 5'd5, 5'd6, 16'h0001); id_pc = 32'h110;
    for (int k = 0; k < 2; k++) begin
      ex_load = 1'b1; ex_dst = (k == 0) ? 5'd5 : 5'd6;
      #1 total++;
      if (stall_if !== 1'b1) begin bad++; $display("FAIL luh_stall%0d got=%b exp=1", k, stall_if); end
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'(k + 1)));
      @(posedge clk); #1;
      e = sb.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL luh_bubble%0d got=%h exp=%h", k, obs, e); end
      ex_load = 1'b0;
      #1 total++;
      if (stall_if !== 1'b0) begin bad++; $display("FAIL luh_release%0d got=%b exp=0", k, stall_if); end
      sb.push_back(mk(1, 32'h110, 32'h1005, 32'h1006, 32'h1, 5, 6, 6, 6'h08, 6'h01, 16'(k + 1)));
      @(posedge clk); #1;
      e = sb.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL luh_load%0d got=%h exp=%h", k, obs, e); end
    end
    ex_load = 1'b1; ex_dst = 5'd0;
    id_instr = rtype(5'd0, 5'd7, 5'd2, 6'h20); id_pc = 32'h114;
    #1 total++;
    if (stall_if !== 1'b0) begin bad++; $display("FAIL luh_r0 got=%b exp=0", stall_if); end
    sb.push_back(mk(1, 32'h114, 32'h0, 32'h1007, 32'h1020, 0, 7, 2, 6'h00, 6'h20, 2));
    @(posedge clk); #1;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL luh_r0_load got=%h exp=%h", obs, e); end
    quiet();
  endtask

  task automatic test_flush_hold();
    exp_t frozen;
    ex_load = 1'b1; ex_dst = 5'd5; flush = 1'b1;
    id_instr = itype(6'h08, 5'd5, 5'd6, 16'h0001); id_pc = 32'h118;
    #1 total++;
    if (stall_if !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall_if); end
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    @(posedge clk); #1;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL flush_luh got=%h exp=%h", obs, e); end
    quiet();
    id_instr = itype(6'h08, 5'd1, 5'd2, 16'h0010); id_pc = 32'h120;
    frozen = mk(1, 32'h120, 32'h1001, 32'h1002, 32'h10, 1, 2, 2, 6'h08, 6'h10, 2);
    sb.push_back(frozen);
    @(posedge clk); #1;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL pre_hold got=%h exp=%h", obs, e); end
    hold = 1'b1; ex_load = 1'b1; ex_dst = 5'd5;
    id_instr = itype(6'h08, 5'd5, 5'd6, 16'h0001); id_pc = 32'h124;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(frozen);
      @(posedge clk); #1;
      e = sb.pop_front(); total++;
      if (obs !== e || stall_if !== 1'b0) begin
        bad++; $display("FAIL hold%0d got=%h stall=%b exp=%h stall=0", k, obs, stall_if, e);
      end
    end
    quiet();
    sb.push_back(mk(1, 32'h124, 32'h1005, 32'h1006, 32'h1, 5, 6, 6, 6'h08, 6'h01, 2));
    @(posedge clk); #1;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL post_hold got=%h exp=%h", obs, e); end
  endtask

  task automatic test_back_to_back_imm();
    row_t rows [8];
    rows[0] = '{1, itype(6'h0D, 5'd1, 5'd2, 16'h8001), 32'h200,
                mk(1, 32'h200, 32'h1001, 32'h1002, 32'h00008001, 1, 2, 2, 6'h0D, 6'h01, 2)};
    rows[1] = '{1, itype(6'h08, 5'd1, 5'd2, 16'h8001), 32'h204,
                mk(1, 32'h204, 32'h1001, 32'h1002, 32'hFFFF8001, 1, 2, 2, 6'h08, 6'h01, 2)};
    rows[2] = '{1, itype(6'h0F, 5'd0, 5'd7, 16'h1234), 32'h208,
                mk(1, 32'h208, 32'h0, 32'h1007, 32'h12340000, 0, 7, 7, 6'h0F, 6'h34, 2)};
    rows[3] = '{1, {6'h03, 26'h0000010}, 32'h20C,
                mk(1, 32'h20C, 32'h0, 32'h0, 32'h00000010, 0, 0, 31, 6'h03, 6'h10, 2)};
    rows[4] = '{1, itype(6'h2B, 5'd1, 5'd3, 16'h0004), 32'h210,
                mk(1, 32'h210, 32'h1001, 32'h1003, 32'h00000004, 1, 3, 0, 6'h2B, 6'h04, 2)};
    rows[5] = '{1, itype(6'h04, 5'd1, 5'd3, 16'hFFFE), 32'h214,
                mk(1, 32'h214, 32'h1001, 32'h1003, 32'hFFFFFFFE, 1, 3, 0, 6'h04, 6'h3E, 2)};
    rows[6] = '{1, itype(6'h0E, 5'd1, 5'd2, 16'hFFFF), 32'h218,
                mk(1, 32'h218, 32'h1001, 32'h1002, 32'h0000FFFF, 1, 2, 2, 6'h0E, 6'h3F, 2)};
    rows[7] = '{0, itype(6'h08, 5'd1, 5'd2, 16'h0005), 32'h21C,
                mk(0, 32'h21C, 32'h1001, 32'h1002, 32'h00000005, 1, 2, 0, 6'h08, 6'h05, 2)};
    for (int k = 0; k < 8; k++) begin
      id_valid = rows[k].v; id_instr = rows[k].instr; id_pc = rows[k].pc;
      sb.push_back(rows[k].e);
      @(posedge clk); #1;
      e = sb.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL imm_row%0d got=%h exp=%h", k, obs, e); end
    end
    id_valid = 1'b1;
  endtask

  task automatic test_saturate_and_reset();
    ex_load = 1'b1; ex_dst = 5'd5;
    id_instr = itype(6'h08, 5'd5, 5'd6, 16'h0001); id_pc = 32'h300;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF));
    repeat (65540) @(posedge clk);
    #1 e = sb.pop_front(); total++;
    if (obs !== e || stall_if !== 1'b1) begin
      bad++; $display("FAIL saturate got=%h stall=%b exp=%h stall=1", obs, stall_if, e);
    end
    #3 rst = 1'b1;
    #1 total++;
    if (obs !== '0 || stall_if !== 1'b0) begin
      bad++; $display("FAIL reset_mid_stall got=%h stall=%b exp=0 stall=0", obs, stall_if);
    end
    #1 rst = 1'b0; ex_load = 1'b0;
    sb.push_back(mk(1, 32'h300, 32'h1005, 32'h1006, 32'h1, 5, 6, 6, 6'h08, 6'h01, 0));
    @(posedge clk); #1;
    e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL after_reset got=%h exp=%h", obs, e); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'd0;
    rf[8] = 32'h11;
    id_valid = 1'b0; id_instr = 32'd0; id_pc = 32'd0;
    quiet();
    test_reset();
    test_wb_bypass();
    test_mem_priority();
    test_load_use();
    test_flush_hold();
    test_back_to_back_imm();
    test_saturate_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode-side operand stage of the 5-stage pipelined MIPS core, directly upstream of the ID/EX boundary.
- Drives the register file read addresses from the IF/ID instruction and receives the two read data words.
- Applies MEM/WB bypassing, detects load-use hazards and inserts bubbles.
- Registers the decoded operands into the ID/EX pipeline register for the execute stage.

Parameters:
- DW, 32, datapath width.
- AW, 5, register address width.
- CNTW, 16, width of the load-use bubble counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  IF/ID holds a valid instruction.
- id_instr  in  32  IF/ID instruction word.
- id_pc  in  32  IF/ID PC+4.
- rAddr  out  5  regfile port 1 address; equals id_instr[25:21] (rs).
- rAddr2  out  5  regfile port 2 address; equals id_instr[20:16] (rt).
- rDout  in  32  regfile port 1 data; reads register 0 as 0.
- rDout2  in  32  regfile port 2 data.
- ex_load  in  1  instruction currently in EX is a load.
- ex_dst  in  5  EX destination register.
- mem_wEna  in  1  MEM-stage instruction writes a register.
- mem_wAddr  in  5  MEM-stage destination.
- mem_res  in  32  MEM-stage ALU result.
- wb_wEna  in  1  WB write enable (same signal as regfile wEna).
- wb_wAddr  in  5  WB destination.
- wb_wIn  in  32  WB write data.
- hold  in  1  global freeze (memory stall).
- flush  in  1  squash the instruction in ID (taken branch/jump).
- stall_if  out  1  hold PC and IF/ID.
- ex_valid  out  1  ID/EX valid.
- ex_pc  out  32  ID/EX PC+4.
- ex_opA  out  32  rs operand after bypass.
- ex_opB  out  32  rt operand after bypass.
- ex_imm  out  32  extended immediate.
- ex_rs, ex_rt  out  5 each  source register numbers.
- ex_wAddr  out  5  destination register number.
- ex_opcode, ex_funct  out  6 each  instr[31:26], instr[5:0].
- bubble_cnt  out  CNTW  count of load-use bubbles inserted.

Behaviour:
- Reset (asynchronous, rst=1): every registered output clears to 0, including ex_valid and bubble_cnt. stall_if is combinational and reads 0 while rst=1.
- rAddr and rAddr2 are purely combinational from id_instr.
- Bypass is combinational; the first matching rule wins:
  - If the address is 0, the operand is 0.
  - Else if mem_wEna and mem_wAddr equals the address, use mem_res.
  - Else if wb_wEna and wb_wAddr equals the address, use wb_wIn. The regfile writes at the clock edge, so a same-cycle read returns the old value and this bypass is mandatory.
  - Else use the regfile data.
- Load-use hazard: luh = id_valid & ex_load & (ex_dst != 0) & (ex_dst == rs | ex_dst == rt). Both sources are treated as used regardless of instruction type.
- stall_if = luh & ~flush & ~hold.
- Immediate extension:
  - Opcodes 0x0C, 0x0D, 0x0E (andi, ori, xori) zero-extend instr[15:0].
  - lui (0x0F) produces {instr[15:0], 16'b0}.
  - All other opcodes sign-extend instr[15:0].
- Destination register:
  - opcode 0 selects rd = instr[15:11].
  - opcode 0x03 (jal) selects 31.
  - Branches (0x04–0x07), stores (0x28–0x2B) and j (0x02) select 0.
  - All other opcodes select rt.
- ID/EX update on each rising edge; the first matching rule wins:
  1. hold: all ID/EX registers and bubble_cnt keep their values.
  2. flush: insert a bubble (ex_valid=0, ex_wAddr=0, other fields 0).
  3. luh: insert a bubble and increment bubble_cnt. bubble_cnt saturates at all-ones.
  4. Otherwise: load the decoded fields; ex_valid is set to id_valid. When id_valid=0, ex_wAddr is forced to 0.
- Latency: one cycle from the ID inputs to the ID/EX outputs. A load-use stall lasts exactly one cycle, because the following cycle's ex_load refers to the bubble.
- Simultaneous flush and luh: flush wins, no stall, and the counter is not incremented.
- rst asserted mid-stall: outputs clear immediately. The first edge after release loads normally.

Test Plan:
- Reset: assert rst asynchronously between edges → all ex_* and bubble_cnt read 0 at once; stall_if=0.
- WB bypass: regfile r8=0x11, wb_wEna=1, wb_wAddr=8, wb_wIn=0x22, instr add $3,$8,$0 → next edge ex_opA=0x22, ex_opB=0, ex_wAddr=3.
- MEM-over-WB priority: mem and wb both target r9 (mem_res=0xAAAA, wb_wIn=0xBBBB), instr uses rt=9 → ex_opB=0xAAAA. The same setup with address 0 → operand 0.
- Load-use: ex_load=1, ex_dst=5, instr uses rs=5 → stall_if=1 for one cycle, ex_valid=0, bubble_cnt=1. The next cycle (ex_load=0) loads the instruction.
- Flush and luh together → ex_valid=0, stall_if=0, bubble_cnt unchanged. hold=1 for 3 cycles → ex_* frozen, bubble_cnt frozen.
- Immediates: ori imm 0x8001 → ex_imm=0x00008001; addi imm 0x8001 → 0xFFFF8001; lui 0x1234 → 0x12340000; jal → ex_wAddr=31; sw → ex_wAddr=0.
